// File: rtl/sram_rw_ext.sv
`timescale 1ns/1ps
// sram_rw_ext: single-port read/write SRAM wrapper with per-lane write mask.
// After reset a CLEAR sweep zeroes every word before accesses are accepted.
// Reads return data sampled at the accepting edge, with latency 1 (OUT_REG=0)
// or 2 (OUT_REG=1). Out-of-range accesses are flagged on RW0_oor, writes to
// them are dropped and reads of them return zero.
module sram_rw_ext #(
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LANES   = 32,
  parameter int LANE_W  = 8,
  parameter int OUT_REG = 0
) (
  input  logic                     RW0_clk,
  input  logic                     RW0_reset,
  input  logic [ADDR_W-1:0]        RW0_addr,
  input  logic                     RW0_en,
  input  logic                     RW0_wmode,
  input  logic [LANES-1:0]         RW0_wmask,
  input  logic [LANES*LANE_W-1:0]  RW0_wdata,
  output logic [LANES*LANE_W-1:0]  RW0_rdata,
  output logic                     RW0_rvalid,
  output logic                     RW0_ready,
  output logic                     RW0_oor
);

  localparam int W = LANES * LANE_W;
  // Depth held one bit wider than the address so DEPTH = 2^ADDR_W compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_L   = ADDR_W'(1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   clear_ptr_r;
  logic [W-1:0]        mem_r [DEPTH];

  logic                acc_s;
  logic                in_range_s;
  logic                wr_acc_s;
  logic                rd_acc_s;
  logic                oor_acc_s;

  logic                rd1_v_r;
  logic [W-1:0]        rd1_d_r;
  logic                rd1_oor_r;
  logic                oor_r;

  // Request qualification: accepted only in IDLE and never on a reset edge.
  always_comb begin
    acc_s      = RW0_en & (state_r == ST_IDLE) & ~RW0_reset;
    in_range_s = ({1'b0, RW0_addr} < DEPTH_L);
    wr_acc_s   = acc_s & RW0_wmode & in_range_s;
    rd_acc_s   = acc_s & ~RW0_wmode;
    oor_acc_s  = acc_s & ~in_range_s;
  end

  // Control FSM: sweep clear_ptr through every word, then sit in IDLE.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      state_r     <= ST_CLEAR;
      clear_ptr_r <= '0;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clear_ptr_r == LAST_L) begin
            state_r     <= ST_IDLE;
            clear_ptr_r <= '0;
          end else begin
            clear_ptr_r <= clear_ptr_r + ONE_L;
          end
        end
        ST_IDLE: begin
          state_r     <= ST_IDLE;
          clear_ptr_r <= '0;
        end
        default: begin
          state_r     <= ST_CLEAR;
          clear_ptr_r <= '0;
        end
      endcase
    end
  end

  // Storage array: cleared word by word by the sweep, otherwise lane-masked writes.
  // Reset alone never touches the contents.
  always_ff @(posedge RW0_clk) begin
    if (!RW0_reset && (state_r == ST_CLEAR)) begin
      mem_r[clear_ptr_r] <= '0;
    end else if (wr_acc_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (RW0_wmask[i]) begin
          mem_r[RW0_addr][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
        end
      end
    end
  end

  // First read stage: capture the word at the accepting edge and hold it until
  // the next accepted read; out-of-range reads capture zero.
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      rd1_v_r   <= 1'b0;
      rd1_d_r   <= '0;
      rd1_oor_r <= 1'b0;
    end else begin
      rd1_v_r   <= rd_acc_s;
      rd1_oor_r <= rd_acc_s & ~in_range_s;
      if (rd_acc_s) begin
        rd1_d_r <= in_range_s ? mem_r[RW0_addr] : '0;
      end
    end
  end

  // Out-of-range flag: writes report one cycle after the edge, reads line up
  // with their rvalid (one stage later when the output register is present).
  always_ff @(posedge RW0_clk) begin
    if (RW0_reset) begin
      oor_r <= 1'b0;
    end else if (OUT_REG != 0) begin
      oor_r <= (oor_acc_s & RW0_wmode) | rd1_oor_r;
    end else begin
      oor_r <= oor_acc_s;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic         rd2_v_r;
      logic [W-1:0] rd2_d_r;

      // Second read stage: retime data and valid; data holds between reads.
      always_ff @(posedge RW0_clk) begin
        if (RW0_reset) begin
          rd2_v_r <= 1'b0;
          rd2_d_r <= '0;
        end else begin
          rd2_v_r <= rd1_v_r;
          if (rd1_v_r) begin
            rd2_d_r <= rd1_d_r;
          end
        end
      end

      assign RW0_rvalid = rd2_v_r;
      assign RW0_rdata  = rd2_d_r;
    end else begin : g_no_out_reg
      assign RW0_rvalid = rd1_v_r;
      assign RW0_rdata  = rd1_d_r;
    end
  endgenerate

  assign RW0_oor   = oor_r;
  assign RW0_ready = (state_r == ST_IDLE);

endmodule

// File: tb/tb_sram_rw_ext.sv
`timescale 1ns/1ps
// Self-checking bench for sram_rw_ext. Three instances share one stimulus:
// u0 DEPTH=512/OUT_REG=0, u1 DEPTH=512/OUT_REG=1, u2 DEPTH=300/OUT_REG=0.
// A behavioural model (word arrays, clear countdown, event queue of results
// due on a given cycle) predicts every output, compared on each negedge.
module tb_sram_rw_ext;
  localparam int AW = 9;
  localparam int LN = 32;
  localparam int LW = 8;
  localparam int W  = LN * LW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          en;
  logic          wmode;
  logic [LN-1:0] wmask;
  logic [W-1:0]  wdata;
  logic [W-1:0]  rdata_w  [3];
  logic          rvalid_w [3];
  logic          ready_w  [3];
  logic          oor_w    [3];

  always #5 clk = ~clk;

  sram_rw_ext #(.ADDR_W(AW), .DEPTH(512), .LANES(LN), .LANE_W(LW), .OUT_REG(0)) u0 (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_w[0]),
    .RW0_rvalid(rvalid_w[0]), .RW0_ready(ready_w[0]), .RW0_oor(oor_w[0]));

  sram_rw_ext #(.ADDR_W(AW), .DEPTH(512), .LANES(LN), .LANE_W(LW), .OUT_REG(1)) u1 (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_w[1]),
    .RW0_rvalid(rvalid_w[1]), .RW0_ready(ready_w[1]), .RW0_oor(oor_w[1]));

  sram_rw_ext #(.ADDR_W(AW), .DEPTH(300), .LANES(LN), .LANE_W(LW), .OUT_REG(0)) u2 (
    .RW0_clk(clk), .RW0_reset(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
    .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata_w[2]),
    .RW0_rvalid(rvalid_w[2]), .RW0_ready(ready_w[2]), .RW0_oor(oor_w[2]));

  // ---------------- behavioural model ----------------
  // Memory variant d: 0 = 512 words (u0,u1), 1 = 300 words (u2).
  int dep_d   [2] = '{512, 300};
  int lat_i   [3] = '{1, 2, 1};
  int mem_of  [3] = '{0, 0, 1};

  logic [W-1:0] mm [2][512];
  int           clr_left [2];
  logic         m_ready  [2];

  typedef struct {
    int           inst;
    int           due;
    logic         is_rd;
    logic [W-1:0] d;
    logic         oor;
  } ev_t;
  ev_t evq[$];

  logic         e_rvalid [3];
  logic         e_oor    [3];
  logic         e_ready  [3];
  logic [W-1:0] e_rdata  [3];

  int cyc;
  bit chk_en;
  int checks;
  int errors;

  // Apply one clock edge's worth of rules to the model, using inputs as sampled.
  task automatic model_edge();
    bit  acc;
    bit  oorf;
    int  d;
    int  j;
    ev_t ev;
    cyc++;
    if (rst) begin
      evq.delete();
      for (int k = 0; k < 2; k++) begin
        clr_left[k] = dep_d[k];
        m_ready[k]  = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        e_rvalid[i] = 1'b0;
        e_oor[i]    = 1'b0;
        e_rdata[i]  = '0;
        e_ready[i]  = 1'b0;
      end
      return;
    end
    // memory updates: sweep or masked write
    for (int k = 0; k < 2; k++) begin
      acc = en && m_ready[k];
      if (clr_left[k] > 0) begin
        mm[k][dep_d[k] - clr_left[k]] = '0;
        clr_left[k]--;
      end else if (acc && wmode && (int'(addr) < dep_d[k])) begin
        for (int l = 0; l < LN; l++)
          if (wmask[l]) mm[k][addr][l*LW +: LW] = wdata[l*LW +: LW];
      end
    end
    // schedule results
    for (int i = 0; i < 3; i++) begin
      d    = mem_of[i];
      acc  = en && m_ready[d];
      oorf = (int'(addr) >= dep_d[d]);
      if (acc && !wmode) begin
        ev.inst = i; ev.due = cyc + lat_i[i] - 1; ev.is_rd = 1'b1; ev.oor = oorf;
        ev.d = oorf ? '0 : mm[d][addr];
        evq.push_back(ev);
      end else if (acc && oorf) begin
        ev.inst = i; ev.due = cyc; ev.is_rd = 1'b0; ev.oor = 1'b1; ev.d = '0;
        evq.push_back(ev);
      end
    end
    // outputs for the cycle following this edge
    for (int i = 0; i < 3; i++) begin
      e_rvalid[i] = 1'b0;
      e_oor[i]    = 1'b0;
    end
    j = 0;
    while (j < evq.size()) begin
      if (evq[j].due == cyc) begin
        if (evq[j].is_rd) begin
          e_rvalid[evq[j].inst] = 1'b1;
          e_rdata[evq[j].inst]  = evq[j].d;
        end
        if (evq[j].oor) e_oor[evq[j].inst] = 1'b1;
        evq.delete(j);
      end else begin
        j++;
      end
    end
    for (int k = 0; k < 2; k++) m_ready[k] = (clr_left[k] == 0);
    for (int i = 0; i < 3; i++) e_ready[i] = m_ready[mem_of[i]];
  endtask

  // ---------------- checking ----------------
  task automatic cmp_bit(string nm, int i, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] cyc %0d: got %b expected %b", nm, i, cyc, act, exp);
    end
  endtask

  task automatic cmp_word(string nm, int i, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[u%0d] cyc %0d: got %h expected %h", nm, i, cyc, act, exp);
    end
  endtask

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        cmp_bit("ready", i, ready_w[i], e_ready[i]);
        cmp_bit("rvalid", i, rvalid_w[i], e_rvalid[i]);
        cmp_bit("oor", i, oor_w[i], e_oor[i]);
        cmp_word("rdata", i, rdata_w[i], e_rdata[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [LN-1:0] m, input logic [W-1:0] dv);
    en = 1'b1; wmode = 1'b1; addr = a; wmask = m; wdata = dv;
    tick();
    en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    en = 1'b1; wmode = 1'b0; addr = a;
    tick();
    en = 1'b0;
  endtask

  task automatic rand_req();
    en    = ($urandom_range(0, 3) != 0);
    wmode = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 1) == 0) addr = AW'($urandom_range(0, 15));
    else                           addr = AW'($urandom_range(0, 511));
    wmask = ($urandom_range(0, 7) == 0) ? '0 : LN'($urandom);
    for (int j = 0; j < W / 32; j++) wdata[j*32 +: 32] = $urandom;
  endtask

  initial begin
    int n;
    checks = 0; errors = 0; cyc = 0; chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin clr_left[k] = 0; m_ready[k] = 1'b0; end
    rst = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wmask = '0; wdata = '0;

    // reset for 3 cycles, then the clear sweep
    repeat (3) tick();
    chk_en = 1'b1;
    cmp_bit("pin_reset_ready", 0, ready_w[0], 1'b0);
    cmp_word("pin_reset_rdata", 1, rdata_w[1], {W{1'b0}});
    rst = 1'b0;
    n = 0;
    while (ready_w[0] !== 1'b1 && n < 600) begin tick(); n++; end
    checks++;
    if (n != 512) begin errors++; $display("FAIL clear_len: got %0d cycles expected 512", n); end

    // last word reads back zero one cycle later
    rd(9'h1FF);
    cmp_bit("pin_rd1ff_valid", 0, rvalid_w[0], 1'b1);
    cmp_word("pin_rd1ff_data", 0, rdata_w[0], {W{1'b0}});

    // partial-lane write
    wr(9'd5, 32'h0000000F, {32{8'hAA}});
    cmp_bit("pin_wr_novalid", 0, rvalid_w[0], 1'b0);
    rd(9'd5);
    cmp_word("pin_mask_data", 0, rdata_w[0], {224'd0, 32'hAAAAAAAA});

    // back-to-back reads through the output register
    wr(9'd1, '1, {32{8'h01}});
    wr(9'd2, '1, {32{8'h02}});
    wr(9'd3, '1, {32{8'h03}});
    en = 1'b1; wmode = 1'b0; addr = 9'd1; tick();
    cmp_bit("pin_or_v0", 1, rvalid_w[1], 1'b0);
    addr = 9'd2; tick();
    cmp_bit("pin_or_v1", 1, rvalid_w[1], 1'b1);
    cmp_word("pin_or_d1", 1, rdata_w[1], {32{8'h01}});
    addr = 9'd3; tick();
    cmp_word("pin_or_d2", 1, rdata_w[1], {32{8'h02}});
    en = 1'b0; tick();
    cmp_bit("pin_or_v3", 1, rvalid_w[1], 1'b1);
    cmp_word("pin_or_d3", 1, rdata_w[1], {32{8'h03}});
    tick();
    cmp_bit("pin_or_v4", 1, rvalid_w[1], 1'b0);

    // read sampled at accept; later write does not disturb held data
    wr(9'd7, '1, {32{8'h11}});
    rd(9'd7);
    wr(9'd7, '1, {32{8'h22}});
    cmp_word("pin_hold_a", 0, rdata_w[0], {32{8'h11}});
    repeat (3) tick();
    cmp_word("pin_hold_b", 0, rdata_w[0], {32{8'h11}});
    rd(9'd7);
    cmp_word("pin_hold_new", 0, rdata_w[0], {32{8'h22}});

    // out-of-range on the 300-word instance
    wr(9'd400, '1, {32{8'h5C}});
    cmp_bit("pin_oor_wr", 2, oor_w[2], 1'b1);
    cmp_bit("pin_oor_wr_u0", 0, oor_w[0], 1'b0);
    rd(9'd400);
    cmp_bit("pin_oor_rd", 2, oor_w[2], 1'b1);
    cmp_bit("pin_oor_rdv", 2, rvalid_w[2], 1'b1);
    cmp_word("pin_oor_rdd", 2, rdata_w[2], {W{1'b0}});
    tick();
    cmp_bit("pin_oor_end", 2, oor_w[2], 1'b0);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin rand_req(); tick(); end
    en = 1'b0;

    // reset mid-clear at clear_ptr = 100, with requests during the sweep
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 100; k++) begin rand_req(); tick(); end
    rst = 1'b1; tick(); rst = 1'b0;
    n = 0;
    while (ready_w[0] !== 1'b1 && n < 600) begin rand_req(); tick(); n++; end
    en = 1'b0;
    checks++;
    if (n != 512) begin errors++; $display("FAIL clear_len_2: got %0d cycles expected 512", n); end

    // more traffic, then a full read-back sweep against the model
    for (int k = 0; k < 300; k++) begin rand_req(); tick(); end
    en = 1'b0; wmask = '0;
    for (int a = 0; a < 512; a++) rd(AW'(a));
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
